scene_draw_sequencer: RTL and testbench

- Pixel-address generator for the game's frame-buffer writer. Emits one (x, y, color) pixel per clock.
- Repeats a fixed object sequence each pass: pipe 1 body, pipe 1 top, pipe 2 body, pipe 2 top, bird.
- On request, a full-screen clear pass (color 0) is inserted after the bird.
- Contains one sequencer FSM plus raster sub-drawers: screen clear, pipe body, pipe top, bird.

---
 rtl/scene_draw_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_scene_draw_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scene_draw_sequencer.sv
// Frame-buffer pixel sequencer: clear pass, two pipes (body + top) and the bird,
// one (x, y, color) per clock with a row-major raster drawer per object phase.
module scene_draw_sequencer #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int PIPE_W    = 40,
    parameter int PIPE_GAP  = 120,
    parameter int BIRD_SIZE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pipe1_x,
    input  logic [10:0] pipe1_y,
    input  logic [10:0] pipe2_x,
    input  logic [10:0] pipe2_y,
    input  logic [10:0] bird_x,
    input  logic [10:0] bird_y,
    input  logic        clear_en,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        color,
    output logic        plot,
    output logic        clear_done
);

    localparam int N_DRAW = 6;
    localparam logic [11:0] LAST_X   = 12'(SCREEN_W - 1);
    localparam logic [11:0] LAST_Y   = 12'(SCREEN_H - 1);
    localparam logic [10:0] LAST_X11 = 11'(SCREEN_W - 1);
    localparam logic [10:0] LAST_Y11 = 11'(SCREEN_H - 1);

    // Encodings double as drawer indices, so drawer gi is enabled in state gi.
    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_P1_BODY = 3'd1,
        ST_P1_TOP  = 3'd2,
        ST_P2_BODY = 3'd3,
        ST_P2_TOP  = 3'd4,
        ST_BIRD    = 3'd5
    } state_t;

    state_t      r_state;
    logic [2:0]  w_state_idx;
    logic        w_cur_done;

    logic [10:0] w_org_x [N_DRAW];
    logic [10:0] w_org_y [N_DRAW];
    logic [10:0] w_end_x [N_DRAW];
    logic [10:0] w_end_y [N_DRAW];
    logic        w_empty [N_DRAW];
    logic        w_en    [N_DRAW];
    logic        w_done  [N_DRAW];
    logic        w_plot  [N_DRAW];
    logic [10:0] w_dx    [N_DRAW];
    logic [10:0] w_dy    [N_DRAW];

    logic [10:0] w_pipe_x [2];
    logic [10:0] w_pipe_y [2];

    assign w_state_idx = r_state;
    assign w_pipe_x[0] = pipe1_x;
    assign w_pipe_y[0] = pipe1_y;
    assign w_pipe_x[1] = pipe2_x;
    assign w_pipe_y[1] = pipe2_y;

    assign w_org_x[0] = '0;
    assign w_org_y[0] = '0;
    assign w_end_x[0] = LAST_X11;
    assign w_end_y[0] = LAST_Y11;
    assign w_empty[0] = 1'b0;

    // Region bounds are computed 12 bits wide so far-right objects cannot wrap.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pipe
            localparam int BODY = 1 + 2 * gi;
            localparam int TOP  = 2 + 2 * gi;
            logic [11:0] w_px;
            logic [11:0] w_py;
            logic [11:0] w_right;
            logic [11:0] w_top_end;

            assign w_px      = {1'b0, w_pipe_x[gi]};
            assign w_py      = {1'b0, w_pipe_y[gi]};
            assign w_right   = w_px + 12'(PIPE_W - 1);
            assign w_top_end = w_py - 12'(PIPE_GAP + 1);

            assign w_org_x[BODY] = w_pipe_x[gi];
            assign w_org_y[BODY] = w_pipe_y[gi];
            assign w_end_x[BODY] = (w_right > LAST_X) ? LAST_X11 : w_right[10:0];
            assign w_end_y[BODY] = LAST_Y11;
            assign w_empty[BODY] = (w_px > LAST_X) || (w_py > LAST_Y);

            assign w_org_x[TOP] = w_pipe_x[gi];
            assign w_org_y[TOP] = '0;
            assign w_end_x[TOP] = (w_right > LAST_X) ? LAST_X11 : w_right[10:0];
            assign w_end_y[TOP] = (w_top_end > LAST_Y) ? LAST_Y11 : w_top_end[10:0];
            assign w_empty[TOP] = (w_px > LAST_X) || (w_py <= 12'(PIPE_GAP));
        end
    endgenerate

    logic [11:0] w_bx;
    logic [11:0] w_by;
    logic [11:0] w_bird_right;
    logic [11:0] w_bird_bottom;

    assign w_bx          = {1'b0, bird_x};
    assign w_by          = {1'b0, bird_y};
    assign w_bird_right  = w_bx + 12'(BIRD_SIZE - 1);
    assign w_bird_bottom = w_by + 12'(BIRD_SIZE - 1);
    assign w_org_x[5]    = bird_x;
    assign w_org_y[5]    = bird_y;
    assign w_end_x[5]    = (w_bird_right > LAST_X) ? LAST_X11 : w_bird_right[10:0];
    assign w_end_y[5]    = (w_bird_bottom > LAST_Y) ? LAST_Y11 : w_bird_bottom[10:0];
    assign w_empty[5]    = (w_bx > LAST_X) || (w_by > LAST_Y);

    // Raster drawers: track the object while idle, freeze and scan while enabled.
    generate
        for (gi = 0; gi < N_DRAW; gi++) begin : g_draw
            logic [10:0] r_x;
            logic [10:0] r_y;
            logic [10:0] r_org_x;
            logic [10:0] r_end_x;
            logic [10:0] r_end_y;
            logic        r_empty;
            logic        w_row_end;

            assign w_en[gi]   = (w_state_idx == 3'(gi));
            assign w_row_end  = (r_x == r_end_x);
            assign w_done[gi] = w_en[gi] && (r_empty || (w_row_end && (r_y == r_end_y)));
            assign w_plot[gi] = w_en[gi] && !r_empty;
            assign w_dx[gi]   = r_x;
            assign w_dy[gi]   = r_y;

            always_ff @(posedge clk) begin
                if (reset || !w_en[gi]) begin
                    r_x     <= w_org_x[gi];
                    r_y     <= w_org_y[gi];
                    r_org_x <= w_org_x[gi];
                    r_end_x <= w_end_x[gi];
                    r_end_y <= w_end_y[gi];
                    r_empty <= w_empty[gi];
                end else if (!w_done[gi]) begin
                    if (w_row_end) begin
                        r_x <= r_org_x;
                        r_y <= r_y + 11'd1;
                    end else begin
                        r_x <= r_x + 11'd1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        x          = '0;
        y          = '0;
        plot       = 1'b0;
        w_cur_done = 1'b0;
        for (int i = 0; i < N_DRAW; i++) begin
            if (w_en[i]) begin
                x          = w_dx[i];
                y          = w_dy[i];
                plot       = w_plot[i];
                w_cur_done = w_done[i];
            end
        end
    end

    assign color      = (r_state != ST_CLEAR);
    assign clear_done = w_done[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
        end else begin
            case (r_state)
                ST_CLEAR:   if (w_cur_done) r_state <= ST_P1_BODY;
                ST_P1_BODY: if (w_cur_done) r_state <= ST_P1_TOP;
                ST_P1_TOP:  if (w_cur_done) r_state <= ST_P2_BODY;
                ST_P2_BODY: if (w_cur_done) r_state <= ST_P2_TOP;
                ST_P2_TOP:  if (w_cur_done) r_state <= ST_BIRD;
                ST_BIRD:    if (w_cur_done) r_state <= clear_en ? ST_CLEAR : ST_P1_BODY;
                default:    r_state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_scene_draw_sequencer.sv
// Bench for scene_draw_sequencer on a reduced screen: a queue-of-pixels model
// checked every cycle, plus hand-computed pixels at phase boundaries.
module tb_scene_draw_sequencer;

    localparam int W   = 128;
    localparam int H   = 96;
    localparam int PW  = 16;
    localparam int GAP = 24;
    localparam int B   = 8;

    localparam int PH_CLEAR = 0;
    localparam int PH_P1B   = 1;
    localparam int PH_P1T   = 2;
    localparam int PH_P2B   = 3;
    localparam int PH_P2T   = 4;
    localparam int PH_BIRD  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] p1x, p1y, p2x, p2y, bx, by;
    logic        cen;
    logic [10:0] x, y;
    logic        color, plot, clear_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    scene_draw_sequencer #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .PIPE_W   (PW),
        .PIPE_GAP (GAP),
        .BIRD_SIZE(B)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .pipe1_x   (p1x),
        .pipe1_y   (p1y),
        .pipe2_x   (p2x),
        .pipe2_y   (p2y),
        .bird_x    (bx),
        .bird_y    (by),
        .clear_en  (cen),
        .x         (x),
        .y         (y),
        .color     (color),
        .plot      (plot),
        .clear_done(clear_done)
    );

    // Cycle 1 is the first pixel shown after the last reset edge.
    always @(posedge clk) cyc <= rst ? 1 : cyc + 1;

    typedef struct {
        int px;
        int py;
        bit pl;
    } pix_t;

    pix_t q[$];
    int   qi;
    int   phase;
    bit   exp_valid = 1'b0;
    int   exp_x, exp_y;
    bit   exp_color, exp_plot, exp_cd;

    function automatic int next_phase(input int ph, input bit clr);
        case (ph)
            PH_CLEAR: return PH_P1B;
            PH_P1B:   return PH_P1T;
            PH_P1T:   return PH_P2B;
            PH_P2B:   return PH_P2T;
            PH_P2T:   return PH_BIRD;
            default:  return clr ? PH_CLEAR : PH_P1B;
        endcase
    endfunction

    // Every on-screen pixel of the phase's region, in scan order.
    function automatic void build(input int ph);
        int ox = 0, oy = 0, x0 = 0, x1 = -1, y0 = 0, y1 = -1;
        q.delete();
        case (ph)
            PH_CLEAR: begin x1 = W - 1; y1 = H - 1; end
            PH_P1B: begin ox = int'(p1x); oy = int'(p1y); x0 = ox; x1 = ox + PW - 1; y0 = oy; y1 = H - 1; end
            PH_P1T: begin ox = int'(p1x); x0 = ox; x1 = ox + PW - 1; y1 = int'(p1y) - GAP - 1; end
            PH_P2B: begin ox = int'(p2x); oy = int'(p2y); x0 = ox; x1 = ox + PW - 1; y0 = oy; y1 = H - 1; end
            PH_P2T: begin ox = int'(p2x); x0 = ox; x1 = ox + PW - 1; y1 = int'(p2y) - GAP - 1; end
            default: begin ox = int'(bx); oy = int'(by); x0 = ox; x1 = ox + B - 1; y0 = oy; y1 = oy + B - 1; end
        endcase
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                if (xx < W && yy < H) q.push_back('{xx, yy, 1'b1});
        if (q.size() == 0) q.push_back('{ox, oy, 1'b0});
        qi = 0;
    endfunction

    initial begin
        phase = PH_CLEAR;
        qi    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                phase = PH_CLEAR;
                build(phase);
                exp_valid = 1'b1;
            end else if (exp_valid) begin
                qi++;
                if (qi >= q.size()) begin
                    phase = next_phase(phase, cen);
                    build(phase);
                end
            end
            if (exp_valid) begin
                exp_x     = q[qi].px;
                exp_y     = q[qi].py;
                exp_plot  = q[qi].pl;
                exp_color = (phase != PH_CLEAR);
                exp_cd    = (phase == PH_CLEAR) && (qi == q.size() - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            n_checks++;
            if (x === 11'(exp_x) && y === 11'(exp_y) && color === exp_color &&
                plot === exp_plot && clear_done === exp_cd)
                n_pass++;
            else
                $display("FAIL model cyc=%0d: got x=%0d y=%0d color=%b plot=%b clear_done=%b, want x=%0d y=%0d color=%b plot=%b clear_done=%b",
                         cyc, x, y, color, plot, clear_done, exp_x, exp_y, exp_color, exp_plot, exp_cd);
        end
    end

    task automatic check_at(input int n, input int ex, input int ey, input bit ec,
                            input bit ep, input bit ecd, input string name);
        int guard = 0;
        @(negedge clk);
        while (cyc != n && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (cyc == n && x === 11'(ex) && y === 11'(ey) && color === ec &&
            plot === ep && clear_done === ecd)
            n_pass++;
        else
            $display("FAIL %s: got cyc=%0d x=%0d y=%0d color=%b plot=%b clear_done=%b, want cyc=%0d x=%0d y=%0d color=%b plot=%b clear_done=%b",
                     name, cyc, x, y, color, plot, clear_done, n, ex, ey, ec, ep, ecd);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        do begin
            @(posedge clk);
            #2;
            guard++;
        end while (cyc != n && guard < 60000);
        if (cyc != n) begin
            n_checks++;
            $display("FAIL wait_cyc: got cyc=%0d, want cyc=%0d", cyc, n);
        end
    endtask

    initial begin
        cen = 1'b0;
        p1x = 11'd20;  p1y = 11'd60;
        p2x = 11'd120; p2y = 11'd20;
        bx  = 11'd20;  by  = 11'd20;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        check_at(1,     0,   0,  0, 1, 0, "clear_first");
        check_at(2,     1,   0,  0, 1, 0, "clear_second");
        check_at(128,   127, 0,  0, 1, 0, "clear_row0_end");
        check_at(129,   0,   1,  0, 1, 0, "clear_row1_start");
        check_at(12287, 126, 95, 0, 1, 0, "clear_penultimate");
        check_at(12288, 127, 95, 0, 1, 1, "clear_last");
        check_at(12289, 20,  60, 1, 1, 0, "p1body_first");
        check_at(12864, 35,  95, 1, 1, 0, "p1body_last");
        check_at(12865, 20,  0,  1, 1, 0, "p1top_first");
        check_at(13440, 35,  35, 1, 1, 0, "p1top_last");
        check_at(13441, 120, 20, 1, 1, 0, "p2body_first");
        check_at(13448, 127, 20, 1, 1, 0, "p2body_clip_row_end");
        check_at(13449, 120, 21, 1, 1, 0, "p2body_row2");
        check_at(14048, 127, 95, 1, 1, 0, "p2body_last");
        check_at(14049, 120, 0,  1, 0, 0, "p2top_empty");
        check_at(14050, 20,  20, 1, 1, 0, "bird_first");
        check_at(14113, 27,  27, 1, 1, 0, "bird_last");
        check_at(14114, 20,  60, 1, 1, 0, "pass2_p1body_first");

        wait_cyc(14200);
        p1x = 11'd40; bx = 11'd124; by = 11'd92;
        wait_cyc(14300);
        cen = 1'b1;
        wait_cyc(14310);
        cen = 1'b0;
        check_at(14689, 35,  95, 1, 1, 0, "p1body_frozen_last");
        check_at(14690, 40,  0,  1, 1, 0, "p1top_new_x");
        check_at(15875, 124, 92, 1, 1, 0, "bird_clipped_first");
        wait_cyc(15880);
        cen = 1'b1;
        check_at(15890, 127, 95, 1, 1, 0, "bird_clipped_last");
        check_at(15891, 0,   0,  0, 1, 0, "clear_after_bird");
        wait_cyc(15900);
        cen = 1'b0;
        check_at(28178, 127, 95, 0, 1, 1, "clear2_last");
        check_at(28179, 40,  60, 1, 1, 0, "p1body_after_clear");
        check_at(29331, 120, 20, 1, 1, 0, "pass3_p2body_first");

        wait_cyc(29400);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        check_at(1,     0,   0,  0, 1, 0, "reset_clear_origin");
        check_at(2,     1,   0,  0, 1, 0, "reset_clear_second");
        check_at(12289, 40,  60, 1, 1, 0, "p1body_after_reset");
        check_at(13441, 120, 20, 1, 1, 0, "p2body_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
